// File: rtl/patbuf_pkg.sv
// Shared definitions for the pattern-buffer controller: default geometry,
// anti-starvation limit and the streamer state encoding.
package patbuf_pkg;

    localparam int unsigned BUFP_WIDTH   = 3;   // 8 buffers
    localparam int unsigned FIELDP_WIDTH = 5;   // 32 fields per buffer
    localparam int unsigned BUFFER_WIDTH = 8;   // field data width
    localparam int unsigned STARVE_LIMIT = 4;   // denied FETCH cycles before the core is stalled

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } strm_state_t;

endpackage

// File: rtl/patbuf_store.sv
// Single-port synchronous-read pattern store. One access per cycle; read data
// is captured into one of two output registers so the core's read result and
// the streamer's current beat are each held independently of later accesses.
//   clk, reset      : clock, synchronous active-low reset (output registers only)
//   en, we          : access enable, write select
//   rsel            : read destination (0 = core register, 1 = stream register)
//   addr, wdata     : {buffer, field} address and write data
//   rdata_core      : last core read result
//   rdata_strm      : last streamer read result
module patbuf_store #(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic                  rsel,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata_core,
    output logic [data_width-1:0] rdata_strm
);

    localparam int unsigned DEPTH = 1 << addr_width;

    logic [data_width-1:0] mem [DEPTH];

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read capture, steered to the requester's register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_core <= '0;
            rdata_strm <= '0;
        end else if (en && !we) begin
            if (rsel) begin
                rdata_strm <= mem[addr];
            end else begin
                rdata_core <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/patbuf_ctrl.sv
// Pattern-buffer controller: shares the single-ported store between the pat
// core (priority) and an output streamer, with an anti-starvation counter that
// stalls the core when the streamer has been denied too long.
//   core side   : bufp, fieldp, core_rd, fieldwp, field_out, write_en ->
//                 field_in, field_in_valid, core_stall, write_err
//   commit side : commit, commit_buf -> busy, commit_err
//   stream side : stream_data, stream_valid, stream_last <- stream_ready
module patbuf_ctrl
    import patbuf_pkg::*;
#(
    parameter int unsigned bufp_width   = BUFP_WIDTH,
    parameter int unsigned fieldp_width = FIELDP_WIDTH,
    parameter int unsigned buffer_width = BUFFER_WIDTH,
    parameter int unsigned starve_limit = STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bufp_width-1:0]   bufp,
    input  logic [fieldp_width-1:0] fieldp,
    input  logic                    core_rd,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    write_en,
    output logic [buffer_width-1:0] field_in,
    output logic                    field_in_valid,
    output logic                    core_stall,
    input  logic                    commit,
    input  logic [bufp_width-1:0]   commit_buf,
    output logic [buffer_width-1:0] stream_data,
    output logic                    stream_valid,
    input  logic                    stream_ready,
    output logic                    stream_last,
    output logic                    busy,
    output logic                    commit_err,
    output logic                    write_err
);

    localparam int unsigned ADDR_W = bufp_width + fieldp_width;
    localparam int unsigned CNT_W  = $clog2(starve_limit + 1);

    localparam logic [fieldp_width-1:0] IDX_LAST = {fieldp_width{1'b1}};
    localparam logic [fieldp_width-1:0] IDX_ONE  = fieldp_width'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(starve_limit);
    localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);

    strm_state_t             state, state_n;
    logic [fieldp_width-1:0] idx, idx_n;
    logic [bufp_width-1:0]   strm_buf, strm_buf_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    q_valid, q_valid_n;
    logic [bufp_width-1:0]   q_buf, q_buf_n;
    logic                    stream_valid_n, stream_last_n;
    logic                    busy_n, core_stall_n;
    logic                    field_in_valid_n, commit_err_n, write_err_n;

    logic                    core_req, core_gnt, strm_gnt, wr_drop, final_hs;
    logic                    mem_en, mem_we, mem_rsel;
    logic [ADDR_W-1:0]       mem_addr;

    // Arbitration. core_stall is registered and already encodes
    // "FETCH with the counter at its limit", so it forces the streamer grant.
    always_comb begin
        core_req = write_en || core_rd;
        core_gnt = core_req && !core_stall;
        strm_gnt = (state == ST_FETCH) && (core_stall || !core_req);
        wr_drop  = core_gnt && write_en && busy && (bufp == strm_buf);
        final_hs = (state == ST_HOLD) && stream_ready && (idx == IDX_LAST);
    end

    // Store port mux; a dropped write performs no access at all.
    always_comb begin
        mem_en   = strm_gnt || (core_gnt && !wr_drop);
        mem_we   = core_gnt && write_en;
        mem_rsel = !core_gnt;
        mem_addr = core_gnt ? {bufp, (write_en ? fieldwp : fieldp)} : {strm_buf, idx};
    end

    patbuf_store #(
        .addr_width (ADDR_W),
        .data_width (buffer_width)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .en         (mem_en),
        .we         (mem_we),
        .rsel       (mem_rsel),
        .addr       (mem_addr),
        .wdata      (field_out),
        .rdata_core (field_in),
        .rdata_strm (stream_data)
    );

    // Streamer FSM, starve counter, commit queue and error pulses.
    always_comb begin
        state_n          = state;
        idx_n            = idx;
        strm_buf_n       = strm_buf;
        cnt_n            = cnt;
        q_valid_n        = q_valid;
        q_buf_n          = q_buf;
        stream_valid_n   = stream_valid;
        stream_last_n    = stream_last;
        commit_err_n     = 1'b0;
        write_err_n      = wr_drop;
        field_in_valid_n = core_gnt && !write_en;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
            end
            ST_FETCH: begin
                if (strm_gnt) begin
                    state_n        = ST_HOLD;
                    cnt_n          = '0;
                    stream_valid_n = 1'b1;
                    stream_last_n  = (idx == IDX_LAST);
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (stream_ready) begin
                    stream_valid_n = 1'b0;
                    stream_last_n  = 1'b0;
                    if (idx == IDX_LAST) begin
                        state_n = ST_IDLE;
                    end else begin
                        idx_n   = idx + IDX_ONE;
                        state_n = ST_FETCH;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Queued commit starts straight after the final handshake.
        if (final_hs && q_valid) begin
            state_n    = ST_FETCH;
            strm_buf_n = q_buf;
            idx_n      = '0;
            q_valid_n  = 1'b0;
        end

        // The final-handshake cycle frees the queue slot for a new commit.
        if (commit) begin
            if ((state == ST_IDLE) || (final_hs && !q_valid)) begin
                state_n    = ST_FETCH;
                strm_buf_n = commit_buf;
                idx_n      = '0;
            end else if (!q_valid || final_hs) begin
                q_valid_n = 1'b1;
                q_buf_n   = commit_buf;
            end else begin
                commit_err_n = 1'b1;
            end
        end

        busy_n       = (state_n != ST_IDLE) || q_valid_n;
        core_stall_n = (state_n == ST_FETCH) && (cnt_n == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            strm_buf       <= '0;
            cnt            <= '0;
            q_valid        <= 1'b0;
            q_buf          <= '0;
            stream_valid   <= 1'b0;
            stream_last    <= 1'b0;
            busy           <= 1'b0;
            core_stall     <= 1'b0;
            field_in_valid <= 1'b0;
            commit_err     <= 1'b0;
            write_err      <= 1'b0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            strm_buf       <= strm_buf_n;
            cnt            <= cnt_n;
            q_valid        <= q_valid_n;
            q_buf          <= q_buf_n;
            stream_valid   <= stream_valid_n;
            stream_last    <= stream_last_n;
            busy           <= busy_n;
            core_stall     <= core_stall_n;
            field_in_valid <= field_in_valid_n;
            commit_err     <= commit_err_n;
            write_err      <= write_err_n;
        end
    end

endmodule

// File: tb/tb_patbuf_ctrl.sv
// Scoreboard bench for patbuf_ctrl: stimulus pushes expected core reads and
// stream beats (from a plain array model of the buffers) into queues; monitor
// processes pop and compare whenever the DUT presents data.
module tb_patbuf_ctrl;

    localparam int unsigned NB = 8;
    localparam int unsigned NF = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] bufp;
    logic [4:0] fieldp;
    logic       core_rd;
    logic [4:0] fieldwp;
    logic [7:0] field_out;
    logic       write_en;
    logic [7:0] field_in;
    logic       field_in_valid;
    logic       core_stall;
    logic       commit;
    logic [2:0] commit_buf;
    logic [7:0] stream_data;
    logic       stream_valid;
    logic       stream_ready;
    logic       stream_last;
    logic       busy;
    logic       commit_err;
    logic       write_err;

    patbuf_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .bufp           (bufp),
        .fieldp         (fieldp),
        .core_rd        (core_rd),
        .fieldwp        (fieldwp),
        .field_out      (field_out),
        .write_en       (write_en),
        .field_in       (field_in),
        .field_in_valid (field_in_valid),
        .core_stall     (core_stall),
        .commit         (commit),
        .commit_buf     (commit_buf),
        .stream_data    (stream_data),
        .stream_valid   (stream_valid),
        .stream_ready   (stream_ready),
        .stream_last    (stream_last),
        .busy           (busy),
        .commit_err     (commit_err),
        .write_err      (write_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [7:0] d; int unsigned c; } rd_exp_t;
    typedef struct { logic [7:0] d; logic last; } beat_t;

    logic [7:0] mem_m [NB][NF];
    rd_exp_t    rq[$];
    beat_t      sq[$];

    int ready_mode = 1;       // 0 low, 1 high, 2 random
    int werr_cnt   = 0;
    int cerr_cnt   = 0;
    int stall_cnt  = 0;
    int beat_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core-side monitor: read results and error/stall pulse counting.
    always @(negedge clk) begin
        if (field_in_valid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %0h expected no read", field_in);
            end else begin
                rd_exp_t e;
                e = rq.pop_front();
                check("core_rd_data", {24'd0, field_in}, {24'd0, e.d});
                check("core_rd_cycle", cyc, e.c);
            end
        end
        if (write_err)  werr_cnt++;
        if (commit_err) cerr_cnt++;
        if (core_stall) stall_cnt++;
    end

    // Stream-side driver/monitor: drives ready, compares beats, checks holding.
    logic       hold_prev = 1'b0;
    logic [7:0] held_d;
    logic       held_l;
    always @(negedge clk) begin
        logic rdy;
        case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (stream_valid && hold_prev) begin
            check("stream_hold_data", {24'd0, stream_data}, {24'd0, held_d});
            check("stream_hold_last", {31'd0, stream_last}, {31'd0, held_l});
        end
        stream_ready = rdy;
        if (stream_valid && rdy) begin
            hold_prev = 1'b0;
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected no beat", stream_data);
            end else begin
                beat_t b;
                b = sq.pop_front();
                check("stream_data", {24'd0, stream_data}, {24'd0, b.d});
                check("stream_last", {31'd0, stream_last}, {31'd0, b.last});
                beat_cnt++;
            end
        end else if (stream_valid) begin
            hold_prev = 1'b1;
            held_d    = stream_data;
            held_l    = stream_last;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // One core access, held across stalls; model updated when it takes effect.
    task automatic core_op(input bit wr, input bit rd, input logic [2:0] b,
                           input logic [4:0] f, input logic [7:0] d, input bit drop);
        bit stalled;
        bufp      = b;
        fieldp    = f;
        fieldwp   = f;
        field_out = d;
        write_en  = wr;
        core_rd   = rd;
        do begin
            stalled = core_stall;
            if (!stalled) begin
                if (wr) begin
                    if (!drop) mem_m[b][f] = d;
                end else if (rd) begin
                    rq.push_back('{d: mem_m[b][f], c: cyc + 1});
                end
            end
            @(posedge clk);
            @(negedge clk);
        end while (stalled);
        write_en = 1'b0;
        core_rd  = 1'b0;
    endtask

    task automatic push_buffer(input logic [2:0] b);
        for (int f = 0; f < int'(NF); f++) begin
            sq.push_back('{d: mem_m[b][f], last: (f == int'(NF) - 1)});
        end
    endtask

    task automatic commit_op(input logic [2:0] b);
        write_en   = 1'b0;
        core_rd    = 1'b0;
        commit     = 1'b1;
        commit_buf = b;
        @(posedge clk);
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_field_in"},       {24'd0, field_in},    32'd0);
        check({tag, "_field_in_valid"}, {31'd0, field_in_valid}, 32'd0);
        check({tag, "_core_stall"},     {31'd0, core_stall},  32'd0);
        check({tag, "_stream_data"},    {24'd0, stream_data}, 32'd0);
        check({tag, "_stream_valid"},   {31'd0, stream_valid}, 32'd0);
        check({tag, "_stream_last"},    {31'd0, stream_last}, 32'd0);
        check({tag, "_busy"},           {31'd0, busy},        32'd0);
        check({tag, "_commit_err"},     {31'd0, commit_err},  32'd0);
        check({tag, "_write_err"},      {31'd0, write_err},   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int w0, c0, s0, b0;
        reset = 1'b0; bufp = '0; fieldp = '0; core_rd = 1'b0; fieldwp = '0;
        field_out = '0; write_en = 1'b0; commit = 1'b0; commit_buf = '0;
        stream_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Fill every buffer; buffer 1 gets idx+0x10.
        for (int b = 0; b < int'(NB); b++) begin
            for (int f = 0; f < int'(NF); f++) begin
                core_op(1'b1, 1'b0, 3'(b), 5'(f),
                        (b == 1) ? 8'(f + 16) : 8'($urandom_range(0, 255)), 1'b0);
            end
        end

        // Write then read back; a combined write+read performs only the write.
        core_op(1'b1, 1'b0, 3'd2, 5'd5, 8'hA5, 1'b0);
        core_op(1'b0, 1'b1, 3'd2, 5'd5, 8'h00, 1'b0);
        core_op(1'b1, 1'b1, 3'd6, 5'd9, 8'h3C, 1'b0);
        core_op(1'b0, 1'b1, 3'd6, 5'd9, 8'h00, 1'b0);
        repeat (2) @(negedge clk);

        // Plain stream of buffer 1.
        @(posedge clk); ready_mode = 1; @(negedge clk);
        b0 = beat_cnt;
        push_buffer(3'd1);
        commit_op(3'd1);
        wait_idle(1000, n);
        check("stream_cycles", n, 32'd64);
        check("stream_beats", beat_cnt - b0, 32'd32);
        check("stream_drained", sq.size(), 32'd0);

        // Continuous core reads during a stream: one stall per field.
        s0 = stall_cnt;
        push_buffer(3'd0);
        commit_op(3'd0);
        for (int i = 0; i < 1000 && busy; i++) begin
            core_op(1'b0, 1'b1, 3'd5, 5'($urandom_range(0, 31)), 8'h00, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("stall_count", stall_cnt - s0, 32'd32);
        check("starve_drained", sq.size(), 32'd0);

        // Write to the streaming buffer is dropped; other buffers are writable.
        w0 = werr_cnt;
        push_buffer(3'd1);
        commit_op(3'd1);
        core_op(1'b1, 1'b0, 3'd1, 5'd3, 8'h77, 1'b1);
        core_op(1'b1, 1'b0, 3'd3, 5'd7, 8'h5C, 1'b0);
        wait_idle(1000, n);
        check("write_err_count", werr_cnt - w0, 32'd1);
        core_op(1'b0, 1'b1, 3'd1, 5'd3, 8'h00, 1'b0);
        core_op(1'b0, 1'b1, 3'd3, 5'd7, 8'h00, 1'b0);
        repeat (2) @(negedge clk);

        // Three back-to-back commits: two stream, the third is dropped.
        @(posedge clk); ready_mode = 2; @(negedge clk);
        c0 = cerr_cnt;
        push_buffer(3'd0);
        push_buffer(3'd1);
        commit_op(3'd0);
        commit_op(3'd1);
        commit_op(3'd2);
        wait_idle(2000, n);
        check("commit_err_count", cerr_cnt - c0, 32'd1);
        check("queue_drained", sq.size(), 32'd0);

        // Sink back-pressure for 10 cycles mid-stream.
        @(posedge clk); ready_mode = 1; @(negedge clk);
        push_buffer(3'd2);
        commit_op(3'd2);
        repeat (10) @(negedge clk);
        @(posedge clk); ready_mode = 0;
        repeat (10) @(negedge clk);
        @(posedge clk); ready_mode = 1; @(negedge clk);
        wait_idle(1000, n);
        check("backpressure_drained", sq.size(), 32'd0);

        // Reset while a beat is held: stream aborts, outputs return to reset.
        @(posedge clk); ready_mode = 0; @(negedge clk);
        push_buffer(3'd3);
        commit_op(3'd3);
        commit_op(3'd4);
        for (int i = 0; i < 50 && !stream_valid; i++) @(negedge clk);
        check("hold_before_reset", {31'd0, stream_valid}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        sq.delete();
        reset = 1'b1;
        @(posedge clk); ready_mode = 1;
        repeat (80) @(negedge clk);
        check("no_beats_after_reset", {31'd0, busy}, 32'd0);

        // Randomised traffic: core ops on buffers 4..7, commits of 0..3 when idle.
        @(posedge clk); ready_mode = 2; @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r == 0 && !busy) begin
                logic [2:0] cb;
                cb = 3'($urandom_range(0, 3));
                push_buffer(cb);
                commit_op(cb);
            end else if (r == 1) begin
                @(negedge clk);
            end else begin
                bit wr, rd;
                wr = 1'($urandom_range(0, 1));
                rd = 1'($urandom_range(0, 1));
                core_op(wr, rd,
                        wr ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 7)),
                        5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 1'b0);
            end
        end
        @(posedge clk); ready_mode = 1; @(negedge clk);
        wait_idle(2000, n);
        repeat (3) @(negedge clk);
        check("final_stream_queue", sq.size(), 32'd0);
        check("final_read_queue", rq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
